// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial shift-out link: FSM encoding,
// line idle level and counter sizing.
package serial_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    localparam logic SIN_IDLE = 1'b1;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// Bundle of serial input, output-enable and received-word status
// signals for serial_word_receiver.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             SIN;
    logic             OE;
    logic [WIDTH-1:0] QQ;
    logic             VALID;
    logic             FERR;
    logic             PERR;
    logic             BUSY;

    modport master (
        output SIN, OE,
        input  QQ, VALID, FERR, PERR, BUSY
    );

    modport slave (
        input  SIN, OE,
        output QQ, VALID, FERR, PERR, BUSY
    );
endinterface

// File: rtl/serial_word_receiver_tristate.sv
// tristate_word_driver: puts a registered word on a shared bus
// unless OE (active-high disable) is set.
module tristate_word_driver #(
    parameter int WIDTH = 4
) (
    input  logic             OE,
    input  logic [WIDTH-1:0] QQ,
    output tri   [WIDTH-1:0] Q
);

    assign Q = OE ? {WIDTH{1'bz}} : QQ;

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-in, parallel-out receiver (start, MSB-first data, stop).
// Define SERIAL_WORD_RECEIVER_PARITY_EN to add an even-parity bit.
module serial_word_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    serial_word_receiver_if.slave bus,
    output tri   [WIDTH-1:0]     Q
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] qq_q, qq_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            qq_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            qq_q    <= qq_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        qq_d    = qq_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.SIN != SIN_IDLE) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                shreg_d = {shreg_q[WIDTH-2:0], bus.SIN};
                cnt_d   = cnt_q + 1'b1;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                par_d   = par_q ^ bus.SIN;
                if (cnt_q == CW'(WIDTH - 1)) state_d = ST_PARITY;
`else
                if (cnt_q == CW'(WIDTH - 1)) state_d = ST_STOP;
`endif
            end
            ST_PARITY: begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                par_d   = par_q ^ bus.SIN;
`endif
                state_d = ST_STOP;
            end
            ST_STOP: begin
                state_d = ST_IDLE;
                // Framing error wins over parity error.
                if (!bus.SIN) begin
                    ferr_d = 1'b1;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                end else if (par_q) begin
                    perr_d = 1'b1;
`endif
                end else begin
                    qq_d    = shreg_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.QQ    = qq_q;
    assign bus.VALID = valid_q;
    assign bus.FERR  = ferr_q;
    assign bus.BUSY  = (state_q != ST_IDLE);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    assign bus.PERR  = perr_q;
`else
    assign bus.PERR  = 1'b0;
`endif

    tristate_word_driver #(
        .WIDTH (WIDTH)
    ) u_drv (
        .OE (bus.OE),
        .QQ (qq_q),
        .Q  (Q)
    );

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-in, parallel-out receiver.
- Accepts a framed bitstream (start bit, WIDTH data bits MSB first, optional parity bit, stop bit) on one line, one bit per clock.
- Presents the captured word on a registered output and on a tri-state bus.
- Sits at the far end of a shift-out link fed by the team's parallel-load shift registers; reassembles the word those registers shift out.

Parameters:
- WIDTH, 4, number of data bits per frame (legal range 2..16).

Ports:
- CLK  input  1  system clock, all state changes on rising edge
- RST  input  1  asynchronous, active-high reset
- SIN  input  1  serial data line; idles high
- OE  input  1  output disable: 1 -> Q is high-impedance, 0 -> Q drives QQ
- Q  output  WIDTH  tri-state bus copy of QQ
- QQ  output  WIDTH  last correctly framed word (registered)
- VALID  output  1  one-cycle pulse: QQ was updated this cycle
- FERR  output  1  one-cycle pulse: stop bit sampled low, frame discarded
- PERR  output  1  one-cycle pulse: parity mismatch, frame discarded (PARITY_EN only, else constant 0)
- BUSY  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, RST=1):
  - state=IDLE, bit counter=0, shift register=0.
  - QQ=0, VALID=0, FERR=0, PERR=0, BUSY=0.
  - Q is Z if OE=1, else 0.
- Reset asserted mid-frame aborts the frame with no pulse. After RST falls, the receiver waits for a fresh start bit.
- State machine, one SIN sample per rising edge:
  - IDLE: SIN=0 -> DATA, counter=0. SIN=1 -> stay.
  - DATA: shift register <= {shreg[WIDTH-2:0], SIN} (MSB first); counter++. After the WIDTH-th bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample SIN as the parity bit -> STOP.
  - STOP, sample SIN:
    - SIN=1 and no parity error: QQ <= shreg, VALID=1.
    - SIN=0: FERR=1, QQ held.
    - SIN=1 with parity error: PERR=1, QQ held.
    - All cases -> IDLE.
- Outputs are registered:
  - VALID, FERR and PERR are high for exactly the one cycle following the edge that sampled the stop bit.
  - At most one of the three is high in any cycle.
- Latency: frame = 1 + WIDTH (+1 with parity) + 1 cycles. QQ changes on the edge that samples the stop bit.
- Back-to-back frames: the state is IDLE for the cycle after STOP, so the next start bit may be sampled one cycle after the stop bit. A start bit arriving during STOP is not detected.
- BUSY=1 in DATA, PARITY and STOP.
- Q = OE ? all-Z : QQ. Purely combinational, does not affect internal state; OE may toggle at any time.
- Counter width is clog2(WIDTH)+1; it never wraps within a frame.

Optional Feature:
- Macro: SERIAL_WORD_RECEIVER_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits.
  - XOR of the WIDTH data bits and the parity bit must be 0; otherwise PERR pulses at the stop edge and QQ is held.
  - A framing error takes precedence over a parity error (FERR only).
- Undefined: no PARITY state, PERR tied 0, frame length WIDTH+2.

Decomposition:
- Shared package serial_link_pkg holds:
  - state encoding constants ST_IDLE, ST_DATA, ST_PARITY, ST_STOP (2-bit);
  - SIN idle level constant (1'b1);
  - the counter-width function.
- One natural sub-module: tristate_word_driver (WIDTH, OE, QQ -> Q), reusable by the transmit-side shift register.

Test Plan:
- Reset then SIN=1 for 5 cycles -> QQ=0, VALID=0, BUSY=0; with OE=1 -> Q=zzzz.
- WIDTH=4, SIN: 0,1,0,1,1,1 (start, 1011, stop) -> BUSY high for 5 cycles, QQ=4'b1011, one-cycle VALID, Q=1011 with OE=0.
- Same frame with stop bit 0 -> FERR one cycle, QQ keeps its previous value, VALID stays 0.
- Two frames 1011 then 0110 with one idle cycle between -> two VALID pulses, QQ=1011 then 0110.
- RST pulse after 2 data bits, then a full frame 1100 -> no pulse from the aborted frame, QQ=1100 after the new frame.
- PARITY_EN: frame 1011 with parity bit 0 -> PERR pulse, QQ held; parity bit 1 -> VALID, QQ=1011.
